hazard_ctrl: RTL

Pipeline hazard controller for the 5-stage pipelined CPU. It sits beside the forwarding unit and sequences the IF/ID/EX front end. It detects load-use hazards, tracks the multi-cycle multiply/divide unit (MDU) and stalls dependent instructions, and flushes wrong-path instructions on a taken branch/jump resolved in EX. Its outputs drive the PC write enable, the IF/ID write and flush controls, the ID/EX bubble mux and the MDU start strobe.

---
 rtl/hazard_ctrl_if.sv | 34 +++
 rtl/hazard_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard controller interface: ID/EX hazard inputs and front-end control outputs.
// master = pipeline side driving hazard inputs, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [4:0] IFID_Rs;
  logic [4:0] IFID_Rt;
  logic       IFID_UsesRt;
  logic       IFID_IsMdu;
  logic       IFID_ReadsHiLo;
  logic [4:0] IDEX_Rt;
  logic       IDEX_MemRead;
  logic       EX_BranchTaken;

  logic       PC_Write;
  logic       IFID_Write;
  logic       IFID_Flush;
  logic       IDEX_Bubble;
  logic       Mdu_Start;
  logic       Mdu_Busy;
  logic [1:0] Ctrl_State;

  modport master (
    output IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_IsMdu, IFID_ReadsHiLo,
           IDEX_Rt, IDEX_MemRead, EX_BranchTaken,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
           Mdu_Start, Mdu_Busy, Ctrl_State
  );

  modport slave (
    input  IFID_Rs, IFID_Rt, IFID_UsesRt, IFID_IsMdu, IFID_ReadsHiLo,
           IDEX_Rt, IDEX_MemRead, EX_BranchTaken,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Bubble,
           Mdu_Start, Mdu_Busy, Ctrl_State
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, MDU busy tracking/stall, branch flush.
// Optional HAZARD_STALL_CNT_EN adds a saturating 32-bit Stall_Cycles counter.
module hazard_ctrl #(
  parameter int MDU_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave hif
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]  Stall_Cycles
`endif
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    STALL_LU  = 2'd1,
    STALL_MDU = 2'd2,
    FLUSH     = 2'd3
  } cause_t;

  localparam logic [3:0] LAT = 4'(MDU_LAT);

  logic [3:0] busy_cnt_reg;
  logic       mdu_start_reg;
  cause_t     state_reg;

  cause_t cause;
  logic   lu_hazard;
  logic   mdu_hazard;
  logic   mdu_busy;
  logic   issue;
  logic   pc_write;
  logic   ifid_write;
  logic   ifid_flush;
  logic   idex_bubble;

  assign mdu_busy = (busy_cnt_reg != 4'd0);

  always_comb begin
    lu_hazard  = hif.IDEX_MemRead && (hif.IDEX_Rt != 5'd0) &&
                 ((hif.IDEX_Rt == hif.IFID_Rs) ||
                  (hif.IFID_UsesRt && (hif.IDEX_Rt == hif.IFID_Rt)));
    mdu_hazard = mdu_busy && (hif.IFID_ReadsHiLo || hif.IFID_IsMdu);

    if (hif.EX_BranchTaken)
      cause = FLUSH;
    else if (mdu_hazard)
      cause = STALL_MDU;
    else if (lu_hazard)
      cause = STALL_LU;
    else
      cause = RUN;

    issue = (cause == RUN) && hif.IFID_IsMdu;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (cause)
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      STALL_MDU, STALL_LU: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
    // Reset holds the front end frozen with a NOP in ID, independent of the clock.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt_reg  <= 4'd0;
      mdu_start_reg <= 1'b0;
      state_reg     <= RUN;
    end else begin
      mdu_start_reg <= issue;
      state_reg     <= cause;
      // An in-flight op is older than any branch, so flushes never touch the counter.
      if (issue)
        busy_cnt_reg <= LAT;
      else if (busy_cnt_reg != 4'd0)
        busy_cnt_reg <= busy_cnt_reg - 4'd1;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_reg <= 32'd0;
    else if (!pc_write && (stall_cnt_reg != 32'hFFFF_FFFF))
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign Stall_Cycles = stall_cnt_reg;
`endif

  assign hif.PC_Write    = pc_write;
  assign hif.IFID_Write  = ifid_write;
  assign hif.IFID_Flush  = ifid_flush;
  assign hif.IDEX_Bubble = idex_bubble;
  assign hif.Mdu_Start   = mdu_start_reg;
  assign hif.Mdu_Busy    = mdu_busy;
  assign hif.Ctrl_State  = state_reg;

endmodule
